// File: rtl/pong_pkg.sv
// pong_pkg
// Definitions shared by the pong ball controller, the paddle converter and the
// matrix driver: default matrix geometry, the game-sequencing state encoding
// and the frame pixel index helper.
package pong_pkg;

    // Default matrix geometry used across the pong blocks.
    localparam int unsigned ROW_DEF = 4;
    localparam int unsigned COL_DEF = 4;

    typedef enum logic [2:0] {
        IDLE,
        SERVE,
        PLAY,
        MISS,
        OVER
    } state_e;

    // Flat frame bit position of pixel (r, c) in a matrix that is `cols` wide.
    function automatic int unsigned idx(input int unsigned r,
                                        input int unsigned c,
                                        input int unsigned cols = COL_DEF);
        return r * cols + c;
    endfunction

endpackage

// File: rtl/pong_tick_gen.sv
// pong_tick_gen
// Divides clk down to a one-cycle ball-step tick.
// Ports:
//   clk    - system clock
//   rst    - synchronous reset, active-high
//   clr_i  - forces the counter back to zero
//   en_i   - counter advances while high
//   tick_o - high in the cycle the counter sits at TICK_DIV-1 (while enabled)
module pong_tick_gen #(
    parameter int unsigned TICK_DIV = 25000000
) (
    input  logic clk,
    input  logic rst,
    input  logic clr_i,
    input  logic en_i,
    output logic tick_o
);

    // TICK_DIV == 1 still needs a 1-bit counter; it then simply stays at 0.
    localparam int unsigned CW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [CW-1:0] LAST = CW'(TICK_DIV - 1);

    logic [CW-1:0] cnt_q, cnt_d;

    assign tick_o = en_i && (cnt_q == LAST);

    always_comb begin
        // NOTE: every signal written here gets a value first, so no latch is inferred.
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (en_i) begin
            cnt_d = tick_o ? '0 : cnt_q + CW'(1);
        end
    end

    always_ff @(posedge clk) begin
        // NOTE: state registers use non-blocking assignments so all flops update together.
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/pong_ball_controller.sv
// pong_ball_controller
// Game sequencing for the pong LED matrix: owns ball position, direction and
// miss count, steps the ball on the divided tick, checks hits against the
// bottom-row paddle mask and composes the registered frame.
// Ports:
//   clk            - system clock
//   rst            - synchronous reset, active-high
//   start          - level; begins a game from IDLE or OVER
//   down_player    - paddle mask, bit c = paddle in column c of the bottom row
//   out_for_matrix - registered frame, bit r*COL+c = pixel (r, c)
//   ball_row       - current ball row
//   ball_col       - current ball column
//   miss_count     - misses this game
//   game_over      - high while in OVER
module pong_ball_controller
    import pong_pkg::*;
#(
    parameter int unsigned ROW        = ROW_DEF,
    parameter int unsigned COL        = COL_DEF,
    parameter int unsigned TICK_DIV   = 25000000,
    parameter int unsigned SERVE_COL  = 0,
    parameter int unsigned MISS_TICKS = 2,
    parameter int unsigned MAX_MISS   = 3
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          start,
    input  logic [COL-1:0]                down_player,
    output logic [COL*ROW-1:0]            out_for_matrix,
    output logic [$clog2(ROW)-1:0]        ball_row,
    output logic [$clog2(COL)-1:0]        ball_col,
    output logic [$clog2(MAX_MISS+1)-1:0] miss_count,
    output logic                          game_over
);

    localparam int unsigned N   = ROW * COL;
    localparam int unsigned RW  = $clog2(ROW);
    localparam int unsigned CLW = $clog2(COL);
    localparam int unsigned MW  = $clog2(MAX_MISS + 1);
    localparam int unsigned TW  = (MISS_TICKS > 1) ? $clog2(MISS_TICKS) : 1;

    localparam logic [RW-1:0]  ROW_LAST  = RW'(ROW - 1);
    localparam logic [RW-1:0]  ROW_ABOVE = RW'(ROW - 2);   // row just above the paddle
    localparam logic [RW-1:0]  ROW_BOUNC = RW'(ROW - 3);
    localparam logic [CLW-1:0] COL_LAST  = CLW'(COL - 1);
    localparam logic [CLW-1:0] COL_SERVE = CLW'(SERVE_COL);
    localparam logic [MW-1:0]  MISS_END  = MW'(MAX_MISS);
    localparam logic [TW-1:0]  HOLD_LAST = TW'(MISS_TICKS - 1);
    localparam logic [N-1:0]   PIX_ONE   = {{(N-1){1'b0}}, 1'b1};

    state_e         state_q, state_d;
    logic [RW-1:0]  row_q, row_d;
    logic [CLW-1:0] col_q, col_d;
    logic           dir_down_q, dir_down_d;
    logic           dir_right_q, dir_right_d;
    logic [MW-1:0]  miss_q, miss_d;
    logic [TW-1:0]  hold_q, hold_d;
    logic [N-1:0]   frame_q, frame_d;
    logic           game_over_q, game_over_d;

    logic           tick;
    logic           step_en;
    logic           go_serve;
    logic [CLW-1:0] col_nxt;
    logic [MW-1:0]  miss_inc;
    logic [N-1:0]   paddle_row;
    logic [N-1:0]   ball_mask;

    // The step counter only runs while the ball is live or the miss is held.
    assign step_en = (state_q == PLAY) || (state_q == MISS);

    pong_tick_gen #(
        .TICK_DIV(TICK_DIV)
    ) u_tick (
        .clk   (clk),
        .rst   (rst),
        .clr_i (!step_en),
        .en_i  (step_en),
        .tick_o(tick)
    );

    assign paddle_row = {down_player, {((ROW - 1) * COL){1'b0}}};
    assign ball_mask  = PIX_ONE << idx(32'(row_q), 32'(col_q), COL);
    assign miss_inc   = miss_q + MW'(1);

    always_comb begin
        state_d     = state_q;
        row_d       = row_q;
        col_d       = col_q;
        dir_down_d  = dir_down_q;
        dir_right_d = dir_right_q;
        miss_d      = miss_q;
        hold_d      = hold_q;
        go_serve    = 1'b0;
        col_nxt     = col_q;

        case (state_q)
            IDLE: begin
                if (start) begin
                    miss_d   = '0;
                    go_serve = 1'b1;
                end
            end
            SERVE: state_d = PLAY;
            PLAY: begin
                if (tick) begin
                    // Column moves first; the hit check looks at the column the
                    // ball is arriving in, not the one it is leaving.
                    if (dir_right_q && col_q == COL_LAST) begin
                        dir_right_d = 1'b0;
                        col_nxt     = CLW'(COL - 2);
                    end else if (!dir_right_q && col_q == '0) begin
                        dir_right_d = 1'b1;
                        col_nxt     = CLW'(1);
                    end else begin
                        col_nxt = dir_right_q ? col_q + CLW'(1) : col_q - CLW'(1);
                    end
                    col_d = col_nxt;

                    if (dir_down_q && row_q == ROW_ABOVE) begin
                        if (down_player[col_nxt]) begin
                            dir_down_d = 1'b0;
                            row_d      = ROW_BOUNC;
                        end else begin
                            row_d   = ROW_LAST;
                            hold_d  = '0;
                            state_d = MISS;
                        end
                    end else if (!dir_down_q && row_q == '0) begin
                        dir_down_d = 1'b1;
                        row_d      = RW'(1);
                    end else begin
                        row_d = dir_down_q ? row_q + RW'(1) : row_q - RW'(1);
                    end
                end
            end
            MISS: begin
                if (tick) begin
                    if (hold_q == HOLD_LAST) begin
                        miss_d = miss_inc;
                        if (miss_inc == MISS_END) begin
                            state_d = OVER;
                        end else begin
                            go_serve = 1'b1;
                        end
                    end else begin
                        hold_d = hold_q + TW'(1);
                    end
                end
            end
            OVER: begin
                if (start) begin
                    miss_d   = '0;
                    go_serve = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase

        // The ball is placed on entry so the SERVE frame already shows it.
        if (go_serve) begin
            state_d     = SERVE;
            row_d       = '0;
            col_d       = COL_SERVE;
            dir_down_d  = 1'b1;
            dir_right_d = 1'b1;
        end

        case (state_q)
            IDLE:    frame_d = paddle_row;
            OVER:    frame_d = '1;
            default: frame_d = paddle_row | ball_mask;
        endcase

        game_over_d = (state_d == OVER);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            row_q       <= '0;
            col_q       <= '0;
            dir_down_q  <= 1'b1;
            dir_right_q <= 1'b1;
            miss_q      <= '0;
            hold_q      <= '0;
            frame_q     <= '0;
            game_over_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            row_q       <= row_d;
            col_q       <= col_d;
            dir_down_q  <= dir_down_d;
            dir_right_q <= dir_right_d;
            miss_q      <= miss_d;
            hold_q      <= hold_d;
            frame_q     <= frame_d;
            game_over_q <= game_over_d;
        end
    end

    assign out_for_matrix = frame_q;
    assign ball_row       = row_q;
    assign ball_col       = col_q;
    assign miss_count     = miss_q;
    assign game_over      = game_over_q;

endmodule

// File: tb/tb_pong_ball_controller.sv
// tb_pong_ball_controller
// Directed bench for the pong ball controller on a 4x4 matrix with a 2-cycle
// tick, a 2-tick miss hold and a 2-miss game. Expected values are worked out
// by hand from the ball rules, edge by edge after reset release.
module tb_pong_ball_controller;
    import pong_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [3:0]  down_player;
    logic [15:0] out_for_matrix;
    logic [1:0]  ball_row;
    logic [1:0]  ball_col;
    logic [1:0]  miss_count;
    logic        game_over;

    int total = 0;
    int bad   = 0;

    pong_ball_controller #(
        .ROW       (4),
        .COL       (4),
        .TICK_DIV  (2),
        .SERVE_COL (0),
        .MISS_TICKS(2),
        .MAX_MISS  (2)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .start         (start),
        .down_player   (down_player),
        .out_for_matrix(out_for_matrix),
        .ball_row      (ball_row),
        .ball_col      (ball_col),
        .miss_count    (miss_count),
        .game_over     (game_over)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Advance n rising edges, then settle 1 time unit past the last one.
    task automatic adv(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic check_ball(input string tag, input logic [1:0] r, input logic [1:0] c);
        check({tag, ".row"}, 32'(ball_row), 32'(r));
        check({tag, ".col"}, 32'(ball_col), 32'(c));
    endtask

    initial begin
        rst         = 1'b1;
        start       = 1'b0;
        down_player = 4'b1000;
        adv(2);                                        // E0
        check("rst.state", 32'(dut.state_q), 32'(IDLE));
        check("rst.frame", 32'(out_for_matrix), 32'h0000);
        check("rst.miss", 32'(miss_count), 0);
        check("rst.over", 32'(game_over), 0);
        check_ball("rst", 2'd0, 2'd0);

        // Game 1: paddle at column 3.
        rst   = 1'b0;
        start = 1'b1;
        adv(1);                                        // E1
        start = 1'b0;
        check("serve.state", 32'(dut.state_q), 32'(SERVE));
        check_ball("serve", 2'd0, 2'd0);
        check("idle.frame", 32'(out_for_matrix), 32'h8000);
        adv(1);                                        // E2
        check("play.state", 32'(dut.state_q), 32'(PLAY));
        check("serve.frame", 32'(out_for_matrix), 32'h8001);
        adv(2); check_ball("t1", 2'd1, 2'd1);          // E4
        adv(2); check_ball("t2", 2'd2, 2'd2);          // E6
        adv(2); check_ball("hit", 2'd1, 2'd3);         // E8
        check("hit.dir_down", 32'(dut.dir_down_q), 0);
        adv(2); check_ball("rwall", 2'd0, 2'd2);       // E10
        check("rwall.dir_right", 32'(dut.dir_right_q), 0);
        adv(2); check_ball("top", 2'd1, 2'd1);         // E12
        check("top.dir_down", 32'(dut.dir_down_q), 1);
        adv(2); check_ball("t6", 2'd2, 2'd0);          // E14

        // Paddle briefly covers column 1 between ticks; it must not count.
        down_player = 4'b0010;
        adv(1);                                        // E15
        check("toggle.frame", 32'(out_for_matrix), 32'h2100);
        down_player = 4'b1000;
        adv(1);                                        // E16
        check("miss1.state", 32'(dut.state_q), 32'(MISS));
        check_ball("miss1", 2'd3, 2'd1);
        check("lwall.dir_right", 32'(dut.dir_right_q), 1);
        check("untoggle.frame", 32'(out_for_matrix), 32'h8100);
        adv(1);                                        // E17
        check("miss1.frame", 32'(out_for_matrix), 32'hA000);
        adv(1);                                        // E18
        check("hold.state", 32'(dut.state_q), 32'(MISS));
        check("hold.miss", 32'(miss_count), 0);
        adv(2);                                        // E20
        check("reserve.state", 32'(dut.state_q), 32'(SERVE));
        check("reserve.miss", 32'(miss_count), 1);
        check("reserve.over", 32'(game_over), 0);
        check_ball("reserve", 2'd0, 2'd0);

        // Second serve: paddle at column 0, ball misses in column 3.
        down_player = 4'b0001;
        adv(1);                                        // E21
        check("reserve.frame", 32'(out_for_matrix), 32'h1001);
        adv(2); check_ball("s2t1", 2'd1, 2'd1);        // E23
        start = 1'b1;                                  // ignored in PLAY
        adv(2);                                        // E25
        start = 1'b0;
        check("start_ign.state", 32'(dut.state_q), 32'(PLAY));
        check_ball("s2t2", 2'd2, 2'd2);
        adv(2);                                        // E27
        check("miss2.state", 32'(dut.state_q), 32'(MISS));
        check_ball("miss2", 2'd3, 2'd3);
        adv(1);                                        // E28
        check("miss2.frame", 32'(out_for_matrix), 32'h9000);
        adv(3);                                        // E31
        check("over.state", 32'(dut.state_q), 32'(OVER));
        check("over.miss", 32'(miss_count), 2);
        check("over.flag", 32'(game_over), 1);
        adv(1);                                        // E32
        check("over.frame", 32'(out_for_matrix), 32'hFFFF);
        adv(2);                                        // E34
        check("over.hold", 32'(game_over), 1);

        start = 1'b1;
        adv(1);                                        // E35
        start = 1'b0;
        check("restart.state", 32'(dut.state_q), 32'(SERVE));
        check("restart.miss", 32'(miss_count), 0);
        check("restart.over", 32'(game_over), 0);
        adv(3);                                        // E38
        check_ball("restart.t1", 2'd1, 2'd1);

        // Reset in the middle of play.
        rst = 1'b1;
        adv(1);                                        // E39
        rst = 1'b0;
        check("mrst.state", 32'(dut.state_q), 32'(IDLE));
        check("mrst.frame", 32'(out_for_matrix), 32'h0000);
        check("mrst.miss", 32'(miss_count), 0);
        check("mrst.over", 32'(game_over), 0);
        check_ball("mrst", 2'd0, 2'd0);
        adv(1);                                        // E40
        check("idle2.frame", 32'(out_for_matrix), 32'h1000);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
